id_ex_pipe_reg: RTL

- Parametrised ID→EX pipeline register carrying the full decode bundle (operands, jump operands, instruction, PC, register-file data, GPR/CSR write controls) from Stage_id to Stage_ex.
- Adds a valid/ready handshake with stall back-pressure, synchronous flush for branch/trap redirect, and an optional skid buffer so upstream ready is registered at full throughput.
- Invalid or empty slots present a canonical NOP bubble to EX.

---
 rtl/id_ex_pipe_reg.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID to EX pipeline register with valid/ready handshake, flush and optional skid entry
//
// Purpose:
//   Carries the decode bundle from the ID stage to the EX stage. Main entry M
//   drives the outputs. With SKID_EN=1 a second entry S absorbs the bundle
//   accepted while EX stalls, so o_ready comes straight from a flop. With
//   SKID_EN=0 only M exists and o_ready depends combinationally on i_ready.
//   An empty M presents a canonical NOP bubble to EX.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_flush             synchronous kill of all held entries
//   i_valid / o_ready   upstream handshake from ID
//   o_valid / i_ready   downstream handshake to EX
//   i_* / o_*           decode bundle payload (controls, operands, PC, regs, CSR)
//   o_count             number of entries held (0..2)

module id_ex_pipe_reg #(
   parameter int          XLEN     = 32,
   parameter int          REG_AW   = 5,
   parameter int          CSR_AW   = 12,
   parameter bit          SKID_EN  = 1'b1,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_mem_enable,
   input  logic              i_reg_we,
   input  logic              i_csr_we,
   input  logic [XLEN-1:0]   i_op1,
   input  logic [XLEN-1:0]   i_op2,
   input  logic [XLEN-1:0]   i_op1_jump,
   input  logic [XLEN-1:0]   i_op2_jump,
   input  logic [XLEN-1:0]   i_inst_addr,
   input  logic [XLEN-1:0]   i_reg1_data,
   input  logic [XLEN-1:0]   i_reg2_data,
   input  logic [XLEN-1:0]   i_csr_rdata,
   input  logic [31:0]       i_inst,
   input  logic [REG_AW-1:0] i_reg_wr_addr,
   input  logic [CSR_AW-1:0] i_csr_wr_addr,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_mem_enable,
   output logic              o_reg_we,
   output logic              o_csr_we,
   output logic [XLEN-1:0]   o_op1,
   output logic [XLEN-1:0]   o_op2,
   output logic [XLEN-1:0]   o_op1_jump,
   output logic [XLEN-1:0]   o_op2_jump,
   output logic [XLEN-1:0]   o_inst_addr,
   output logic [XLEN-1:0]   o_reg1_data,
   output logic [XLEN-1:0]   o_reg2_data,
   output logic [XLEN-1:0]   o_csr_rdata,
   output logic [31:0]       o_inst,
   output logic [REG_AW-1:0] o_reg_wr_addr,
   output logic [CSR_AW-1:0] o_csr_wr_addr,
   output logic [1:0]        o_count
);

   localparam int PW = 3 + 8*XLEN + 32 + REG_AW + CSR_AW;

   logic [PW-1:0] in_p;
   logic [PW-1:0] m_p;
   logic [PW-1:0] out_p;
   logic [PW-1:0] bubble;
   logic          m_v;
   logic          s_v;
   logic          in_fire;
   logic          out_fire;

   assign in_p = {i_mem_enable, i_reg_we, i_csr_we,
                  i_op1, i_op2, i_op1_jump, i_op2_jump, i_inst_addr,
                  i_reg1_data, i_reg2_data, i_csr_rdata,
                  i_inst, i_reg_wr_addr, i_csr_wr_addr};

   // Bubble: every field zero except the instruction word, which is the NOP.
   assign bubble = {{(3 + 8*XLEN){1'b0}}, NOP_INST, {(REG_AW + CSR_AW){1'b0}}};

   // Masking is purely combinational on m_v so stale payload never leaks to EX.
   assign out_p = m_v ? m_p : bubble;

   assign {o_mem_enable, o_reg_we, o_csr_we,
           o_op1, o_op2, o_op1_jump, o_op2_jump, o_inst_addr,
           o_reg1_data, o_reg2_data, o_csr_rdata,
           o_inst, o_reg_wr_addr, o_csr_wr_addr} = out_p;

   assign o_valid  = m_v;
   assign in_fire  = i_valid & o_ready;
   assign out_fire = m_v & i_ready;
   assign o_count  = {1'b0, m_v} + {1'b0, s_v};

   generate
      if (SKID_EN) begin : g_skid
         logic [PW-1:0] s_p;
         logic          s_vq;

         // Ready is the inverse of a flop: no path from i_ready to o_ready.
         assign s_v     = s_vq;
         assign o_ready = ~s_vq;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               m_v  <= 1'b0;
               s_vq <= 1'b0;
               m_p  <= '0;
               s_p  <= '0;
            end else if (i_flush) begin
               m_v  <= 1'b0;
               s_vq <= 1'b0;
            end else if (!m_v || out_fire) begin
               if (s_vq) begin
                  // S is older than anything arriving now; it moves up first.
                  // o_ready is low while S is full, so no input lands this edge.
                  m_p  <= s_p;
                  m_v  <= 1'b1;
                  s_vq <= 1'b0;
               end else if (in_fire) begin
                  m_p <= in_p;
                  m_v <= 1'b1;
               end else begin
                  m_v <= 1'b0;
               end
            end else if (in_fire) begin
               // EX stalled with M occupied: park the new bundle in S.
               s_p  <= in_p;
               s_vq <= 1'b1;
            end
         end
      end else begin : g_flat
         assign s_v     = 1'b0;
         assign o_ready = ~m_v | i_ready;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               m_v <= 1'b0;
               m_p <= '0;
            end else if (i_flush) begin
               m_v <= 1'b0;
            end else if (in_fire) begin
               m_p <= in_p;
               m_v <= 1'b1;
            end else if (out_fire) begin
               m_v <= 1'b0;
            end
         end
      end
   endgenerate

endmodule
